// File: rtl/fu_alu_pkg.sv
// fu_alu_pkg: opcode encoding and opcode-class helpers shared by the ALU pipeline.
package fu_alu_pkg;
  typedef enum logic [3:0] {
    OP_ADD, OP_NEG, OP_AND, OP_OR, OP_XOR, OP_INV, OP_SEL_AB, OP_SEL_BA,
    OP_SUB, OP_LT, OP_LTE, OP_GT, OP_GTE, OP_EQ, OP_NE, OP_SEL_XOR_B
  } op_e;
  function automatic logic is_arith(op_e op);
    return op inside {OP_ADD, OP_SUB, OP_NEG};
  endfunction
  function automatic logic is_cmp(op_e op);
    return op inside {OP_LT, OP_LTE, OP_GT, OP_GTE, OP_EQ, OP_NE};
  endfunction
endpackage

// File: rtl/fu_alu_core.sv
// fu_alu_core: combinational operand modification, shared adder and result mux.
module fu_alu_core
  import fu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  op_e              op,
  input  logic             sel,
  input  logic             cin,
  output logic [WIDTH-1:0] z,
  output logic             carry,
  output logic             overflow,
  output logic             zero
);
  logic [WIDTH-1:0] x, y, s;
  logic lt;
  always_comb begin
    x = (op == OP_NEG) ? '0 : a;
    y = (op == OP_NEG) ? ~a : (op == OP_SUB || is_cmp(op)) ? ~b : b;
    {carry, s} = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, cin};
    overflow = (x[WIDTH-1] == y[WIDTH-1]) && (s[WIDTH-1] != x[WIDTH-1]);
    zero = (s == '0);
    lt = s[WIDTH-1] ^ overflow;
    z = s;
    case (op)
      OP_ADD, OP_NEG, OP_SUB: z = s;
      OP_AND:       z = a & b;
      OP_OR:        z = a | b;
      OP_XOR:       z = a ^ b;
      OP_INV:       z = ~a;
      OP_SEL_AB:    z = sel ? b : a;
      OP_SEL_BA:    z = sel ? a : b;
      OP_SEL_XOR_B: z = {b[WIDTH-1:1], sel ^ b[0]};
      OP_LT:        z = {{(WIDTH-1){1'b0}}, lt};
      OP_LTE:       z = {{(WIDTH-1){1'b0}}, lt | zero};
      OP_GT:        z = {{(WIDTH-1){1'b0}}, ~lt & ~zero};
      OP_GTE:       z = {{(WIDTH-1){1'b0}}, ~lt};
      OP_EQ:        z = {{(WIDTH-1){1'b0}}, zero};
      OP_NE:        z = {{(WIDTH-1){1'b0}}, ~zero};
    endcase
  end
endmodule

// File: rtl/fu_alu_pipe.sv
// fu_alu_pipe: two-stage valid/ready ALU with registered flags.
// FU_ALU_EXT_PREC_EN adds the carry (CR) and zero-chain (ZR) registers for multiword add/sub.
module fu_alu_pipe
  import fu_alu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       INST,
  input  logic             SEL,
  input  logic             EXT,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] Z,
  output logic             FLAG_C,
  output logic             FLAG_V,
  output logic             FLAG_Z
);
  logic v1_q, v1_d, sel1_q, sel1_d, v2_q, v2_d;
  logic c_q, c_d, ov_q, ov_d, zf_q, zf_d;
  logic [WIDTH-1:0] a1_q, a1_d, b1_q, b1_d, z_q, z_d, core_z;
  op_e op1_q, op1_d;
  logic load, move, base_cin, cin, zf, core_c, core_v, core_zero;
  assign IN_READY = ~v1_q | ~v2_q | OUT_READY;
  assign load = IN_READY & IN_VALID;
  assign move = v1_q & (~v2_q | OUT_READY);
  assign base_cin = (op1_q == OP_SUB) || (op1_q == OP_NEG) || is_cmp(op1_q);
`ifdef FU_ALU_EXT_PREC_EN
  logic ext1_q, ext1_d, cr_q, cr_d, zr_q, zr_d, chain;
  assign chain = ext1_q & ((op1_q == OP_ADD) || (op1_q == OP_SUB));
  assign cin = chain ? cr_q : base_cin;
  assign zf = core_zero & (~chain | zr_q);
  always_comb begin
    ext1_d = load ? EXT : ext1_q;
    cr_d = (move & is_arith(op1_q)) ? core_c : cr_q;
    zr_d = (move & is_arith(op1_q)) ? zf : zr_q;
  end
  // CR resets to "no carry" and ZR to "all previous words zero".
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ext1_q <= 1'b0;
      cr_q <= 1'b0;
      zr_q <= 1'b1;
    end else begin
      ext1_q <= ext1_d;
      cr_q <= cr_d;
      zr_q <= zr_d;
    end
  end
`else
  logic unused_ext;
  assign unused_ext = EXT;
  assign cin = base_cin;
  assign zf = core_zero;
`endif
  fu_alu_core #(.WIDTH(WIDTH)) u_core (
    .a(a1_q), .b(b1_q), .op(op1_q), .sel(sel1_q), .cin(cin),
    .z(core_z), .carry(core_c), .overflow(core_v), .zero(core_zero)
  );
  always_comb begin
    v1_d = IN_READY ? IN_VALID : v1_q;
    a1_d = load ? A : a1_q;
    b1_d = load ? B : b1_q;
    op1_d = load ? op_e'(INST) : op1_q;
    sel1_d = load ? SEL : sel1_q;
    v2_d = (~v2_q | OUT_READY) ? v1_q : v2_q;
    z_d = move ? core_z : z_q;
    c_d = move ? core_c : c_q;
    ov_d = move ? core_v : ov_q;
    zf_d = move ? zf : zf_q;
  end
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      v1_q <= 1'b0;
      a1_q <= '0;
      b1_q <= '0;
      op1_q <= OP_ADD;
      sel1_q <= 1'b0;
      v2_q <= 1'b0;
      z_q <= '0;
      c_q <= 1'b0;
      ov_q <= 1'b0;
      zf_q <= 1'b0;
    end else begin
      v1_q <= v1_d;
      a1_q <= a1_d;
      b1_q <= b1_d;
      op1_q <= op1_d;
      sel1_q <= sel1_d;
      v2_q <= v2_d;
      z_q <= z_d;
      c_q <= c_d;
      ov_q <= ov_d;
      zf_q <= zf_d;
    end
  end
  assign OUT_VALID = v2_q;
  assign Z = z_q;
  assign FLAG_C = c_q;
  assign FLAG_V = ov_q;
  assign FLAG_Z = zf_q;
endmodule

// File: tb/tb_fu_alu_pipe.sv
// tb_fu_alu_pipe: directed vector table plus handshake, backpressure and reset sequences.
module tb_fu_alu_pipe;
  import fu_alu_pkg::*;
  logic CLK = 0, RST = 1, IN_VALID = 0, IN_READY, SEL = 0, EXT = 0;
  logic OUT_VALID, OUT_READY = 1, FLAG_C, FLAG_V, FLAG_Z;
  logic [31:0] A = 0, B = 0, Z;
  logic [3:0] INST = 0;
  int n_tests = 0, n_fail = 0;
  typedef struct {
    logic [3:0] op;
    logic [31:0] a, b;
    logic sel, ext;
    logic [31:0] z;
    logic c, v, zf, chk;
  } vec_t;
  vec_t tbl[32];
  always #5 CLK = ~CLK;
  fu_alu_pipe #(.WIDTH(32)) dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY), .A(A), .B(B),
    .INST(INST), .SEL(SEL), .EXT(EXT), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Z(Z), .FLAG_C(FLAG_C), .FLAG_V(FLAG_V), .FLAG_Z(FLAG_Z)
  );
  function automatic vec_t mk(op_e op, logic [31:0] a, logic [31:0] b, logic sel, logic ext,
                              logic [31:0] z, logic c, logic v, logic zf, logic chk);
    vec_t r;
    r.op = op; r.a = a; r.b = b; r.sel = sel; r.ext = ext;
    r.z = z; r.c = c; r.v = v; r.zf = zf; r.chk = chk;
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input vec_t t);
    IN_VALID = 1; INST = t.op; A = t.a; B = t.b; SEL = t.sel; EXT = t.ext;
  endtask
  // Streams tbl[lo +: n] back to back and expects each result exactly two cycles later.
  task automatic send(input int lo, input int n);
    for (int c = 0; c <= n; c++) begin
      if (c < n) drive(tbl[lo + c]);
      else IN_VALID = 0;
      @(posedge CLK); #1;
      if (c == 0) chk($sformatf("v%0d_latency", lo), 32'(OUT_VALID), 0);
      else begin
        chk($sformatf("v%0d_valid", lo + c - 1), 32'(OUT_VALID), 1);
        chk($sformatf("v%0d_z", lo + c - 1), Z, tbl[lo + c - 1].z);
        if (tbl[lo + c - 1].chk) begin
          chk($sformatf("v%0d_c", lo + c - 1), 32'(FLAG_C), 32'(tbl[lo + c - 1].c));
          chk($sformatf("v%0d_v", lo + c - 1), 32'(FLAG_V), 32'(tbl[lo + c - 1].v));
          chk($sformatf("v%0d_zf", lo + c - 1), 32'(FLAG_Z), 32'(tbl[lo + c - 1].zf));
        end
      end
    end
  endtask
  initial begin
    int k;
    logic rdy;
    logic [31:0] got[$];
    tbl[0]  = mk(OP_ADD, 32'h7FFFFFFF, 32'h1, 0, 0, 32'h80000000, 0, 1, 0, 1);
    tbl[1]  = mk(OP_SUB, 32'd5, 32'd7, 0, 0, 32'hFFFFFFFE, 0, 0, 0, 1);
    tbl[2]  = mk(OP_LT, 32'hFFFFFFFD, 32'd2, 0, 0, 32'd1, 1, 0, 0, 1);
    tbl[3]  = mk(OP_NEG, 32'd5, 32'd0, 0, 0, 32'hFFFFFFFB, 0, 0, 0, 1);
    tbl[4]  = mk(OP_NEG, 32'd0, 32'd0, 0, 0, 32'd0, 1, 0, 1, 1);
    tbl[5]  = mk(OP_AND, 32'hF0F01234, 32'h0FF0FF00, 0, 0, 32'h00F01200, 0, 0, 0, 0);
    tbl[6]  = mk(OP_OR, 32'hF0000000, 32'h0000000F, 0, 0, 32'hF000000F, 0, 0, 0, 0);
    tbl[7]  = mk(OP_XOR, 32'hFFFF0000, 32'h0F0F0F0F, 0, 0, 32'hF0F00F0F, 0, 0, 0, 0);
    tbl[8]  = mk(OP_INV, 32'h12345678, 32'd0, 0, 0, 32'hEDCBA987, 0, 0, 0, 0);
    tbl[9]  = mk(OP_SEL_AB, 32'd1, 32'd2, 1, 0, 32'd2, 0, 0, 0, 0);
    tbl[10] = mk(OP_SEL_AB, 32'd1, 32'd2, 0, 0, 32'd1, 0, 0, 0, 0);
    tbl[11] = mk(OP_SEL_BA, 32'd1, 32'd2, 1, 0, 32'd1, 0, 0, 0, 0);
    tbl[12] = mk(OP_SEL_BA, 32'd1, 32'd2, 0, 0, 32'd2, 0, 0, 0, 0);
    tbl[13] = mk(OP_SEL_XOR_B, 32'hFFFFFFFF, 32'd5, 1, 0, 32'd4, 0, 0, 0, 0);
    tbl[14] = mk(OP_SEL_XOR_B, 32'hFFFFFFFF, 32'h80000004, 1, 0, 32'h80000005, 0, 0, 0, 0);
    tbl[15] = mk(OP_LTE, 32'd7, 32'd7, 0, 0, 32'd1, 0, 0, 0, 0);
    tbl[16] = mk(OP_LTE, 32'd8, 32'd7, 0, 0, 32'd0, 0, 0, 0, 0);
    tbl[17] = mk(OP_GT, 32'd7, 32'd7, 0, 0, 32'd0, 0, 0, 0, 0);
    tbl[18] = mk(OP_GT, 32'd2, 32'hFFFFFFFD, 0, 0, 32'd1, 0, 0, 0, 0);
    tbl[19] = mk(OP_GTE, 32'hFFFFFFFD, 32'd2, 0, 0, 32'd0, 0, 0, 0, 0);
    tbl[20] = mk(OP_GTE, 32'd7, 32'd7, 0, 0, 32'd1, 0, 0, 0, 0);
    tbl[21] = mk(OP_EQ, 32'd9, 32'd9, 0, 0, 32'd1, 1, 0, 1, 1);
    tbl[22] = mk(OP_EQ, 32'd9, 32'd8, 0, 0, 32'd0, 0, 0, 0, 0);
    tbl[23] = mk(OP_NE, 32'd9, 32'd9, 0, 0, 32'd0, 0, 0, 0, 0);
    tbl[24] = mk(OP_NE, 32'd9, 32'd8, 0, 0, 32'd1, 0, 0, 0, 0);
    tbl[25] = mk(OP_LT, 32'h80000000, 32'd1, 0, 0, 32'd1, 1, 1, 0, 1);
    tbl[26] = mk(OP_GT, 32'h7FFFFFFF, 32'h80000000, 0, 0, 32'd1, 0, 1, 0, 1);
    tbl[27] = mk(OP_ADD, 32'hFFFFFFFF, 32'd1, 0, 0, 32'd0, 1, 0, 1, 1);
    tbl[29] = mk(OP_SUB, 32'd0, 32'd1, 0, 0, 32'hFFFFFFFF, 0, 0, 0, 1);
`ifdef FU_ALU_EXT_PREC_EN
    tbl[28] = mk(OP_ADD, 32'd0, 32'd0, 0, 1, 32'd1, 0, 0, 0, 1);
    tbl[30] = mk(OP_SUB, 32'd1, 32'd0, 0, 1, 32'd0, 1, 0, 0, 1);
`else
    tbl[28] = mk(OP_ADD, 32'd0, 32'd0, 0, 1, 32'd0, 0, 0, 1, 1);
    tbl[30] = mk(OP_SUB, 32'd1, 32'd0, 0, 1, 32'd1, 1, 0, 0, 1);
`endif
    tbl[31] = mk(OP_ADD, 32'd1, 32'd1, 0, 1, 32'd2, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("rst_out_valid", 32'(OUT_VALID), 0);
      chk("rst_z", Z, 0);
      chk("rst_in_ready", 32'(IN_READY), 1);
    end
    chk("rst_flags", {29'd0, FLAG_C, FLAG_V, FLAG_Z}, 0);
    RST = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge CLK); #1;
      chk("idle_out_valid", 32'(OUT_VALID), 0);
    end
    chk("idle_in_ready", 32'(IN_READY), 1);
    send(0, 3);
    send(3, 24);
    @(posedge CLK); #1;
    OUT_READY = 0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      IN_VALID = (k < 4); INST = OP_ADD; A = 32'(10 * (k + 1)); B = 1; EXT = 0; SEL = 0;
      rdy = IN_READY;
      @(posedge CLK);
      if (rdy && IN_VALID) k++;
      #1;
    end
    chk("bp_accepted", 32'(k), 2);
    chk("bp_in_ready", 32'(IN_READY), 0);
    chk("bp_out_valid", 32'(OUT_VALID), 1);
    chk("bp_z_hold", Z, 32'd11);
    IN_VALID = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("bp_z_hold2", Z, 32'd11);
    chk("bp_c_hold", 32'(FLAG_C), 0);
    OUT_READY = 1;
    for (int c = 0; c < 6; c++) begin
      if (OUT_VALID) got.push_back(Z);
      @(posedge CLK); #1;
    end
    chk("bp_drain_count", 32'(got.size()), 2);
    if (got.size() == 2) begin
      chk("bp_drain_0", got[0], 32'd11);
      chk("bp_drain_1", got[1], 32'd21);
    end
    send(27, 2);
    send(29, 2);
    send(27, 1);
    OUT_READY = 0;
    drive(tbl[27]);
    repeat (2) @(posedge CLK);
    #1;
    IN_VALID = 0;
    chk("mid_full_in_ready", 32'(IN_READY), 0);
    chk("mid_full_out_valid", 32'(OUT_VALID), 1);
    #2 RST = 1;
    #1;
    chk("mid_rst_out_valid", 32'(OUT_VALID), 0);
    chk("mid_rst_z", Z, 0);
    chk("mid_rst_c", 32'(FLAG_C), 0);
    chk("mid_rst_in_ready", 32'(IN_READY), 1);
    @(posedge CLK); #1;
    RST = 0;
    OUT_READY = 1;
    @(posedge CLK); #1;
    chk("post_rst_out_valid", 32'(OUT_VALID), 0);
    send(31, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
